// File: rtl/rnd_arb_pkg.sv
// Shared types and helpers for the random-word arbiter.
// Holds the FSM state encoding, default sizing, and the round-robin
// winner search used by rr_arbiter.
package rnd_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int WORD_W_DEF = 8;
  localparam int MAX_NREQ   = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    GRANT = 2'd2
  } state_e;

  // First asserted request scanning ptr, ptr+1, ... modulo nreq.
  // Returns ptr when nothing is requested; callers gate with |req.
  function automatic int next_rr(input logic [MAX_NREQ-1:0] req,
                                 input int                  ptr,
                                 input int                  nreq);
    int w;
    int idx;
    bit found;
    w     = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (ptr + k) % nreq;
      if ((k < nreq) && !found && req[idx[2:0]]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select.
// The search starts at ptr; the caller owns and advances the pointer.
module rr_arbiter
  import rnd_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any_req
);

  logic [MAX_NREQ-1:0] req_ext;

  // Widen the request vector to the helper's fixed width and search.
  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    winner            = PW'(next_rr(req_ext, int'(ptr), NREQ));
  end

  assign any_req = |req;

endmodule

// File: rtl/rnd_word_arbiter.sv
// Random-word arbiter: packs the serial LFSR bit stream into WORD_W-bit
// words and hands each word to exactly one requester, round-robin.
// Build option: define RND_REFRESH_EN to keep shifting bits in while a
// word waits in READY, so the granted word is as fresh as possible.
//
//   state | meaning
//   FILL  | shifting in WORD_W fresh bits, cnt counts 0..WORD_W-1
//   READY | full word waiting, ready=1, arbitrating any requests
//   GRANT | one-cycle delivery: gnt one-hot, valid=1, word stable
module rnd_word_arbiter
  import rnd_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rnd_in,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic              ready
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WORD_W);

  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_READY = READY;
  localparam logic [1:0] ST_GRANT = GRANT;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [PW-1:0]     winner;
  logic              any_req;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state logic: fill, wait/arbitrate, deliver.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    case (state_q)
      ST_FILL: begin
        sh_d = {sh_q[WORD_W-2:0], rnd_in};
        if (cnt_q == CW'(WORD_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
`ifdef RND_REFRESH_EN
        sh_d = {sh_q[WORD_W-2:0], rnd_in};
`endif
        if (any_req) begin
          win_d   = winner;
          gnt_d   = NREQ'(1) << winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Pointer moves past the winner only once the word is delivered.
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        cnt_d   = '0;
        state_d = ST_FILL;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_FILL;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any word or grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign word  = sh_q;
  assign valid = (state_q == ST_GRANT);
  assign ready = (state_q == ST_READY);

endmodule

// File: doc/rnd_word_arbiter.md
Name: rnd_word_arbiter

Overview:
- Sequences the serial PRBS bit stream from the game's LFSR generator into WORD_W-bit random words.
- Shares those words among NREQ game requesters with a fair round-robin policy.
- Every word is built from fresh bits and is delivered to exactly one requester, so two consumers never see the same word.
- Sits between the LFSR and game logic such as enemy spawn, delay timers and dice.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per delivered random word (2..32).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rnd_in  in  1  serial random bit from the LFSR, one new bit per clk.
- req  in  NREQ  level request per requester; held high until granted.
- gnt  out  NREQ  one-hot grant, high for exactly one cycle.
- word  out  WORD_W  random word; meaningful while valid=1.
- valid  out  1  high in the same cycle as gnt; qualifies word.
- ready  out  1  a full word is waiting (state READY).

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=FILL, bit count cnt=0, shift register sh=0, round-robin pointer ptr=0.
  - gnt=0, valid=0, ready=0, word=0.
  - Reset mid-operation discards any partial or waiting word. A grant in flight is dropped at that same edge.
- Shift rule: sh <= {sh[WORD_W-2:0], rnd_in}. The first bit collected ends at the MSB. word = sh.
- FILL state:
  - Each cycle, shift in rnd_in and increment cnt.
  - When cnt==WORD_W-1, the last bit is shifted in, cnt returns to 0 and the next state is READY.
  - FILL lasts exactly WORD_W cycles.
- READY state:
  - ready=1. sh is frozen, unless the optional feature below is enabled.
  - If |req=0, remain in READY.
  - If |req=1, select the winner: the first asserted req[i] searching i = ptr, ptr+1, ... modulo NREQ.
  - The next state is GRANT, with gnt registered to onehot(winner).
- GRANT state (one cycle):
  - gnt=onehot(winner), valid=1, ready=0, word=sh unchanged.
  - ptr <= (winner+1) mod NREQ.
  - Next state is FILL with cnt=0. No bit is shifted in this cycle.
- Latency:
  - Request to grant: 1 cycle if already READY. Otherwise the remaining FILL cycles plus 1.
  - Steady-state word period under continuous requests is WORD_W+2 cycles.
- Requester dropping req while in READY: no grant is issued. If req goes high in the GRANT cycle, that request is not considered until the next READY.
- Simultaneous requests: exactly one gnt bit is ever high. With all req held high, grants rotate 0,1,...,NREQ-1,0,...
- Outputs are registered (state-decoded). There are no combinational paths from req to gnt.

Optional Feature:
- Macro: RND_REFRESH_EN.
- Defined: in READY, sh keeps shifting in rnd_in every cycle, so the delivered word holds the latest WORD_W bits as of the READY→GRANT edge.
- Undefined: sh frozen in READY.
- FILL and GRANT timing are identical in both builds.

Decomposition:
- Package rnd_arb_pkg:
  - state enum {FILL, READY, GRANT}.
  - Default NREQ/WORD_W constants.
  - A function next_rr(req, ptr) returning the winner index.
- Sub-module rr_arbiter (NREQ): combinational round-robin winner select from req and ptr, with an any_req flag. Pointer update stays in the parent.

Test Plan:
- Reset then rnd_in = 1,0,1,1,0,0,1,0 over 8 cycles, req=4'b0001 held → ready=1 after cycle 8; next cycle gnt=4'b0001, valid=1, word=8'hB2.
- All req=4'b1111 held, rnd_in constant 1 → gnt sequence 0001, 0010, 0100, 1000, 0001 every 10 cycles; word=8'hFF each time.
- req=0 for 30 cycles after FILL → ready stays 1, no gnt, word frozen (non-RND_REFRESH_EN build). With RND_REFRESH_EN and rnd_in toggling, word tracks the last 8 bits.
- Grant to requester 2 with req=4'b0101 held → next grant goes to 0 (pointer=3 wraps), not 2.
- rst=1 mid-FILL at cnt=5 and in the GRANT cycle → next cycle gnt=0, valid=0, ready=0, word=0; a full word then needs 8 new cycles.
- req pulsed high only during a GRANT cycle → ignored, no extra grant; exactly one gnt bit high in every cycle (assertion).
